// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// State encoding, initial patterns and pattern period lengths.
package led_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHASE = 2'd1,
        ST_FILL  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    localparam logic [15:0] CHASE_A_INIT = 16'h8000;
    localparam logic [15:0] CHASE_B_INIT = 16'h0007;
    localparam logic [15:0] FILL_INIT    = 16'h0000;
    localparam logic [15:0] BLINK_INIT   = 16'hFFFF;
    localparam logic [15:0] LED_OFF      = 16'h0000;

    localparam int CHASE_PERIOD = 16;
    localparam int FILL_PERIOD  = 32;
    localparam int BLINK_PERIOD = 2;

endpackage

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Tick generator: counts 0..DIV-1 and emits a one-cycle tick on the last count.
// A speed change or an explicit clear restarts the count without a tick.
module tick_gen #(
    parameter int FAST_DIV = 8388608,
    parameter int SLOW_DIV = 33554432
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_speed,
    input  logic i_clear,
    output logic o_tick
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int W = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [W-1:0] FAST_LAST = W'(FAST_DIV - 1);
    localparam logic [W-1:0] SLOW_LAST = W'(SLOW_DIV - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;
    logic         r_speed;
    logic         w_speed_chg;
    logic         w_at_last;

    assign w_last      = i_speed ? SLOW_LAST : FAST_LAST;
    assign w_speed_chg = i_speed ^ r_speed;
    assign w_at_last   = (r_cnt == w_last);
    assign o_tick      = i_run & ~i_clear & ~w_speed_chg & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_speed <= 1'b0;
        end else begin
            r_speed <= i_speed;
            if (i_clear || w_speed_chg) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: IDLE/CHASE/FILL/BLINK selected by buttons,
// patterns stepped by a divided tick enable, all outputs registered.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int FAST_DIV = 8388608,
    parameter int SLOW_DIV = 33554432
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        speed,
    input  logic        mode_btn,
    input  logic        stop_btn,
    output logic [15:0] led,
    output logic [1:0]  mode,
    output logic        period_done
);

    state_t      r_state, w_state_next;
    logic [15:0] r_a, r_b, r_f, r_led;
    logic [15:0] w_a_next, w_b_next, w_f_next, w_led_next;
    logic        r_dir_down, w_dir_next;
    logic        r_pd, w_pd_next;
    logic        w_load, w_tick, w_run;

    assign w_run = en && (r_state != ST_IDLE);

    tick_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_run   (w_run),
        .i_speed (speed),
        .i_clear (w_load),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= CHASE_A_INIT;
            r_b        <= CHASE_B_INIT;
            r_f        <= FILL_INIT;
            r_dir_down <= 1'b0;
            r_led      <= LED_OFF;
            r_pd       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_a        <= w_a_next;
            r_b        <= w_b_next;
            r_f        <= w_f_next;
            r_dir_down <= w_dir_next;
            r_led      <= w_led_next;
            r_pd       <= w_pd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_f_next     = r_f;
        w_dir_next   = r_dir_down;
        w_led_next   = r_led;
        w_pd_next    = 1'b0;

        if (stop_btn) begin
            w_state_next = ST_IDLE;
            w_load       = 1'b1;
        end else if (mode_btn) begin
            w_load = 1'b1;
            case (r_state)
                ST_IDLE:  w_state_next = ST_CHASE;
                ST_CHASE: w_state_next = ST_FILL;
                ST_FILL:  w_state_next = ST_BLINK;
                default:  w_state_next = ST_CHASE;
            endcase
        end

        // Entry reloads every pattern so led shows the new state's start value at once.
        if (w_load) begin
            w_a_next   = CHASE_A_INIT;
            w_b_next   = CHASE_B_INIT;
            w_f_next   = FILL_INIT;
            w_dir_next = 1'b0;
            case (w_state_next)
                ST_CHASE: w_led_next = CHASE_A_INIT | CHASE_B_INIT;
                ST_FILL:  w_led_next = FILL_INIT;
                ST_BLINK: w_led_next = BLINK_INIT;
                default:  w_led_next = LED_OFF;
            endcase
        end else if (w_tick) begin
            case (r_state)
                ST_CHASE: begin
                    w_a_next   = {r_a[0], r_a[15:1]};
                    w_b_next   = {r_b[14:0], r_b[15]};
                    w_led_next = w_a_next | w_b_next;
                    w_pd_next  = (w_a_next == CHASE_A_INIT);
                end
                ST_FILL: begin
                    w_f_next = r_dir_down ? {1'b0, r_f[15:1]}
                                          : {r_f[14:0], 1'b1};
                    if (w_f_next == 16'hFFFF) w_dir_next = 1'b1;
                    if (w_f_next == FILL_INIT) w_dir_next = 1'b0;
                    w_led_next = w_f_next;
                    w_pd_next  = (w_f_next == FILL_INIT);
                end
                ST_BLINK: begin
                    w_led_next = ~r_led;
                    w_pd_next  = (w_led_next == BLINK_INIT);
                end
                default: ;
            endcase
        end
    end

    assign led         = r_led;
    assign mode        = r_state;
    assign period_done = r_pd;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with FAST_DIV=4, SLOW_DIV=8.
// Table of vectors for the main walk, hand sequences for the corner cases.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        speed = 1'b0;
    logic        mode_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic [15:0] led;
    logic [1:0]  mode;
    logic        period_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        mb;
        logic [1:0]  em;
        logic [15:0] el;
        logic        ep;
    } vec_t;

    vec_t vecs[17];

    led_pattern_sequencer #(
        .FAST_DIV (4),
        .SLOW_DIV (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .speed       (speed),
        .mode_btn    (mode_btn),
        .stop_btn    (stop_btn),
        .led         (led),
        .mode        (mode),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] em,
                         input logic [15:0] el, input logic ep);
        checks++;
        if (mode !== em || led !== el || period_done !== ep) begin
            errors++;
            $display("FAIL %s: got mode=%0d led=%h pd=%b, want mode=%0d led=%h pd=%b",
                     nm, mode, led, period_done, em, el, ep);
        end
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
    endtask

    initial begin
        // CHASE walk
        vecs[0]  = '{1,  1'b1, 2'd1, 16'h8007, 1'b0};
        vecs[1]  = '{3,  1'b0, 2'd1, 16'h8007, 1'b0};
        vecs[2]  = '{1,  1'b0, 2'd1, 16'h400E, 1'b0};
        vecs[3]  = '{4,  1'b0, 2'd1, 16'h201C, 1'b0};
        vecs[4]  = '{56, 1'b0, 2'd1, 16'h8007, 1'b1};
        vecs[5]  = '{1,  1'b0, 2'd1, 16'h8007, 1'b0};
        // FILL walk
        vecs[6]  = '{1,  1'b1, 2'd2, 16'h0000, 1'b0};
        vecs[7]  = '{4,  1'b0, 2'd2, 16'h0001, 1'b0};
        vecs[8]  = '{60, 1'b0, 2'd2, 16'hFFFF, 1'b0};
        vecs[9]  = '{4,  1'b0, 2'd2, 16'h7FFF, 1'b0};
        vecs[10] = '{60, 1'b0, 2'd2, 16'h0000, 1'b1};
        vecs[11] = '{1,  1'b0, 2'd2, 16'h0000, 1'b0};
        vecs[12] = '{3,  1'b0, 2'd2, 16'h0001, 1'b0};
        // BLINK walk
        vecs[13] = '{1,  1'b1, 2'd3, 16'hFFFF, 1'b0};
        vecs[14] = '{4,  1'b0, 2'd3, 16'h0000, 1'b0};
        vecs[15] = '{4,  1'b0, 2'd3, 16'hFFFF, 1'b1};
        vecs[16] = '{1,  1'b0, 2'd3, 16'hFFFF, 1'b0};

        #2 rst_n = 1'b0;
        #3;
        check("reset_async", 2'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3);
        check("idle_after_reset", 2'd0, 16'h0000, 1'b0);

        for (int i = 0; i < 17; i++) begin
            mode_btn = vecs[i].mb;
            step(1);
            mode_btn = 1'b0;
            if (vecs[i].cyc > 1) step(vecs[i].cyc - 1);
            check($sformatf("vec%0d", i), vecs[i].em, vecs[i].el, vecs[i].ep);
        end

        // en freeze in CHASE: counter holds at 2, resumes with 2 counts left
        stop_btn = 1'b1;
        step(1);
        stop_btn = 1'b0;
        check("stop_from_blink", 2'd0, 16'h0000, 1'b0);
        pulse_mode();
        check("chase_reenter", 2'd1, 16'h8007, 1'b0);
        step(2);
        en = 1'b0;
        step(20);
        check("en_frozen", 2'd1, 16'h8007, 1'b0);
        en = 1'b1;
        step(1);
        check("en_resume_no_tick", 2'd1, 16'h8007, 1'b0);
        step(1);
        check("en_resume_tick", 2'd1, 16'h400E, 1'b0);

        // speed change in BLINK at the count that would tick
        pulse_mode();
        pulse_mode();
        check("blink_enter", 2'd3, 16'hFFFF, 1'b0);
        step(3);
        speed = 1'b1;
        step(1);
        check("speed_chg_no_tick", 2'd3, 16'hFFFF, 1'b0);
        step(7);
        check("slow_before_tick", 2'd3, 16'hFFFF, 1'b0);
        step(1);
        check("slow_tick1", 2'd3, 16'h0000, 1'b0);
        step(8);
        check("slow_tick2", 2'd3, 16'hFFFF, 1'b1);
        step(1);
        check("slow_pd_one_cycle", 2'd3, 16'hFFFF, 1'b0);
        speed = 1'b0;
        step(1);

        // stop and mode together from FILL: stop wins
        pulse_mode();
        pulse_mode();
        check("fill_enter", 2'd2, 16'h0000, 1'b0);
        step(4);
        check("fill_tick1", 2'd2, 16'h0001, 1'b0);
        stop_btn = 1'b1;
        mode_btn = 1'b1;
        step(1);
        stop_btn = 1'b0;
        mode_btn = 1'b0;
        check("stop_wins", 2'd0, 16'h0000, 1'b0);
        pulse_mode();
        check("chase_after_stop", 2'd1, 16'h8007, 1'b0);

        // async reset mid-FILL
        pulse_mode();
        step(8);
        check("fill_tick2", 2'd2, 16'h0003, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_fill", 2'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(10);
        check("idle_hold_after_reset", 2'd0, 16'h0000, 1'b0);
        pulse_mode();
        check("chase_after_reset", 2'd1, 16'h8007, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter FAST_DIV, default 8388608: tick period in clk cycles when speed=0.
REQ-002 Parameter SLOW_DIV, default 33554432: tick period in clk cycles when speed=1.
REQ-003 Port clk, input, 1: single system clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: 1 = patterns advance; 0 = pattern and tick counter frozen.
REQ-006 Port speed, input, 1: 0 = FAST_DIV, 1 = SLOW_DIV.
REQ-007 Port mode_btn, input, 1: one-cycle pulse (pre-debounced); advance to next mode.
REQ-008 Port stop_btn, input, 1: one-cycle pulse; return to IDLE.
REQ-009 Port led, output, 16: registered LED pattern.
REQ-010 Port mode, output, 2: registered current state encoding.
REQ-011 Port period_done, output, 1: registered one-cycle pulse at completion of a pattern period.

Function
REQ-012 The FSM SHALL have states IDLE=0, CHASE=1, FILL=2, BLINK=3.
REQ-013 Transitions on mode_btn: IDLE->CHASE->FILL->BLINK->CHASE.
REQ-014 stop_btn SHALL force IDLE from any state; stop_btn and mode_btn in the same cycle: stop wins.
REQ-015 On any state entry, the tick counter SHALL clear to 0 and the pattern registers SHALL load initial values; the new state's initial pattern SHALL appear on led in the first cycle mode shows the new state.
REQ-016 Tick counter SHALL count 0..DIV-1 (DIV selected by speed), producing an internal one-cycle tick when count=DIV-1, then wrap to 0.
REQ-017 Tick counter SHALL run only when en=1 and state!=IDLE; otherwise it SHALL hold its value.
REQ-018 A change of speed, detected against a registered copy, SHALL clear the tick counter in that cycle with no tick issued.
REQ-019 Pattern registers SHALL update only on tick; mode transitions SHALL be accepted regardless of en.
REQ-020 IDLE: led=16'h0000, period_done=0.
REQ-021 CHASE: register a, initial 16'h8000, rotates right by one (bit0->bit15) per tick; register b, initial 16'h0007, rotates left by one (bit15->bit0) per tick; led=a|b.
REQ-022 CHASE period_done SHALL pulse on the tick where a returns to 16'h8000 (every 16 ticks).
REQ-023 FILL: register f, initial 16'h0000, with direction flag initial "up"; up: f={f[14:0],1'b1}; down: f={1'b0,f[15:1]}; led=f.
REQ-024 FILL direction SHALL flip to down when f reaches 16'hFFFF and to up when f reaches 16'h0000; sequence 0000,0001,...,FFFF,7FFF,...,0000,0001 (period 32 ticks).
REQ-025 FILL period_done SHALL pulse on the tick where f returns to 16'h0000.
REQ-026 BLINK: led initial 16'hFFFF, inverts per tick; period_done SHALL pulse on the tick returning to 16'hFFFF (every 2 ticks).
REQ-027 period_done SHALL assert in the cycle after the qualifying tick, concurrently with the updated led value, for exactly one cycle.
REQ-028 No derived or gated clocks; all timing via tick enable.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, led=16'h0000, mode=2'd0, period_done=0, tick counter=0, all pattern registers to their initial values, direction=up, registered speed=0.
REQ-030 Reset asserted mid-pattern SHALL discard all progress; after release, operation SHALL resume only on mode_btn.

Structure
REQ-031 A shared package SHALL hold the state encoding, the initial pattern constants (16'h8000, 16'h0007, 16'h0000, 16'hFFFF) and the FILL/CHASE/BLINK period lengths.
REQ-032 The tick generator (counter, speed-change clear, enable hold) SHALL be one sub-module, tick_gen, parameterized by FAST_DIV and SLOW_DIV.

Verification (FAST_DIV=4, SLOW_DIV=8)
REQ-033 Reset, then one mode_btn, en=1, speed=0 -> mode=1, led=8007; after 4 clk, led=4000|000E=400E; 16 ticks later led=8007 and period_done pulses once.
REQ-034 Second mode_btn -> mode=2, led=0000; after 16 ticks led=FFFF, after 17 ticks 7FFF; after 32 ticks 0000 with period_done pulse.
REQ-035 In CHASE, drop en for 20 cycles -> led and tick count frozen; after re-raising en, first tick occurs after the remaining count, not a fresh 4.
REQ-036 In BLINK, toggle speed mid-count -> no tick that cycle, next tick exactly 8 clk later; led alternates FFFF/0000 with period_done every 16 clk.
REQ-037 stop_btn and mode_btn in the same cycle from FILL -> mode=0, led=0000; a following mode_btn -> CHASE with led=8007.
REQ-038 Assert rst_n=0 asynchronously mid-FILL (between clock edges) -> outputs reset before the next edge; after release, led stays 0000 until mode_btn.
